// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard input port: receiver states,
// special scan codes and default widths shared with the ALU input port.
package kb_pkg;

  // Receiver frame position
  typedef enum logic [1:0] {
    KB_IDLE   = 2'd0,
    KB_DATA   = 2'd1,
    KB_PARITY = 2'd2,
    KB_STOP   = 2'd3
  } kb_state_e;

  // Scan-code prefixes: F0 announces a break (key release), E0 an extended key
  localparam logic [7:0] KB_BREAK_CODE = 8'hF0;
  localparam logic [7:0] KB_EXT_CODE   = 8'hE0;

  // Must match the width of the ALU keyboard operand
  localparam int KB_DEFAULT_DATA_WIDTH = 8;
  localparam int KB_DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/kb_input_port_if.sv
// CPU-side bundle of the keyboard port: pop/clear strobes in, queued code and status out.
interface kb_input_port_if #(
  parameter int KB_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                     kb_pop;
  logic                     kb_clear;
  logic [KB_DATA_WIDTH-1:0] input_port_kb;
  logic                     kb_valid;
  logic [CNT_W-1:0]         kb_count;
  logic                     kb_overflow;
  logic                     kb_parity_err;

  // CPU / ALU side
  modport master (
    output kb_pop, kb_clear,
    input  input_port_kb, kb_valid, kb_count, kb_overflow, kb_parity_err
  );

  // Keyboard port side
  modport slave (
    input  kb_pop, kb_clear,
    output input_port_kb, kb_valid, kb_count, kb_overflow, kb_parity_err
  );
endinterface

// File: rtl/kb_fifo.sv
// Small synchronous FIFO for received make codes. A push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle; the head
// reads 0 while empty so the ALU never sees stale codes.
module kb_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic [DATA_WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          full_o,
  output logic                          empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wrPtr_q;
  logic [PTR_W-1:0]      rdPtr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  doPush;
  logic                  doPop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || pop_i);
  assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];
  assign count_o = count_q;

  // Storage write; when full with a pop, the slot being written is the one just vacated
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_ONE;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      if (doPush && !doPop) begin
        count_q <= count_q + CNT_ONE;
      end else if (doPop && !doPush) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/kb_input_port.sv
// PS/2 keyboard receiver feeding the ALU INKEY operand. Synchronizes the
// pins, deframes 11-bit frames with odd parity, drops break sequences and
// queues make codes for the CPU to pop one at a time.
module kb_input_port
  import kb_pkg::*;
#(
  parameter int KB_DATA_WIDTH  = KB_DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH     = KB_DEFAULT_FIFO_DEPTH,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  kb_input_port_if.slave  kb
);
  localparam int BIT_W = $clog2(KB_DATA_WIDTH);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(KB_DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [KB_DATA_WIDTH-1:0] BREAK_CODE = KB_DATA_WIDTH'(KB_BREAK_CODE);

  logic [SYNC_STAGES-1:0]   clkSync_q;
  logic [SYNC_STAGES-1:0]   dataSync_q;
  logic                     clkPrev_q;
  logic                     clkSyncd;
  logic                     dataSyncd;
  logic                     fe;

  kb_state_e                state_q;
  kb_state_e                state_d;
  logic [BIT_W-1:0]         bitCnt_q;
  logic [KB_DATA_WIDTH-1:0] shiftReg_q;
  logic                     parityBit_q;
  logic [WD_W-1:0]          wdog_q;
  logic                     timeout;

  logic                     frameDone;
  logic                     frameGood;
  logic                     frameBad;
  logic                     isBreak;
  logic                     pushReq;
  logic                     breakPending_q;

  logic                     overflow_q;
  logic                     overflow_d;
  logic                     parityErr_q;
  logic                     parityErr_d;

  logic [KB_DATA_WIDTH-1:0] fifoHead;
  logic [CNT_W-1:0]         fifoCount;
  logic                     fifoFull;
  logic                     fifoEmpty;

  assign clkSyncd  = clkSync_q[SYNC_STAGES-1];
  assign dataSyncd = dataSync_q[SYNC_STAGES-1];
  assign fe        = clkPrev_q && !clkSyncd;
  assign timeout   = (state_q != KB_IDLE) && !fe && (wdog_q == WD_LIMIT);

  // Pin synchronizers reset to the idle-high bus level so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSync_q  <= '1;
      dataSync_q <= '1;
      clkPrev_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2_clk};
      dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2_data};
      clkPrev_q  <= clkSyncd;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Receiver next state: advance only on PS/2 falling edges, bail out on watchdog expiry
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = KB_IDLE;
    end else if (fe) begin
      unique case (state_q)
        KB_IDLE:   if (!dataSyncd) state_d = KB_DATA;
        KB_DATA:   if (bitCnt_q == BIT_LAST) state_d = KB_PARITY;
        KB_PARITY: state_d = KB_STOP;
        KB_STOP:   state_d = KB_IDLE;
        default:   state_d = KB_IDLE;
      endcase
    end
  end

  // Receiver outputs: frame verdict on the edge that samples the stop bit
  always_comb begin
    frameDone = 1'b0;
    frameGood = 1'b0;
    if (state_q == KB_STOP && fe) begin
      frameDone = 1'b1;
      frameGood = dataSyncd && (^{shiftReg_q, parityBit_q});
    end
  end

  assign frameBad = frameDone && !frameGood;
  assign isBreak  = (shiftReg_q == BREAK_CODE);
  assign pushReq  = frameGood && !isBreak && !breakPending_q;

  // Frame datapath: LSB-first shift, parity capture and the inter-edge watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      bitCnt_q    <= '0;
      shiftReg_q  <= '0;
      parityBit_q <= 1'b0;
      wdog_q      <= '0;
    end else begin
      if (state_q == KB_IDLE || timeout) begin
        wdog_q   <= '0;
        bitCnt_q <= '0;
      end else if (fe) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + WD_ONE;
      end
      if (fe && state_q == KB_DATA) begin
        shiftReg_q <= {dataSyncd, shiftReg_q[KB_DATA_WIDTH-1:1]};
        bitCnt_q   <= bitCnt_q + BIT_ONE;
      end
      if (fe && state_q == KB_PARITY) begin
        parityBit_q <= dataSyncd;
      end
    end
  end

  // Break filter: F0 arms it, the following good code is swallowed; bad frames leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      breakPending_q <= 1'b0;
    end else if (frameGood) begin
      breakPending_q <= isBreak;
    end
  end

  // Sticky error flags: a same-cycle set beats the clear
  always_comb begin
    overflow_d  = overflow_q && !kb.kb_clear;
    parityErr_d = parityErr_q && !kb.kb_clear;
    if (pushReq && fifoFull && !kb.kb_pop) begin
      overflow_d = 1'b1;
    end
    if (frameBad) begin
      parityErr_d = 1'b1;
    end
  end

  // Sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      parityErr_q <= parityErr_d;
    end
  end

  kb_fifo #(
    .DATA_WIDTH (KB_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushReq),
    .pop_i   (kb.kb_pop),
    .data_i  (shiftReg_q),
    .head_o  (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign kb.input_port_kb = fifoHead;
  assign kb.kb_valid      = !fifoEmpty;
  assign kb.kb_count      = fifoCount;
  assign kb.kb_overflow   = overflow_q;
  assign kb.kb_parity_err = parityErr_q;

endmodule

// File: tb/tb_kb_input_port.sv
// Directed bench for kb_input_port: drives PS/2 frames on the pins and
// checks the queued codes, counts and sticky flags against hand-computed values.
module tb_kb_input_port;
  import kb_pkg::*;

  localparam int TIMEOUT = 5000;

  logic clk;
  logic rst;
  logic ps2Clk;
  logic ps2Data;
  int   checks;
  int   failures;

  kb_input_port_if #(.KB_DATA_WIDTH(8), .FIFO_DEPTH(4)) kbIf ();

  kb_input_port #(
    .KB_DATA_WIDTH  (8),
    .FIFO_DEPTH     (4),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Data),
    .kb       (kbIf)
  );

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One PS/2 bit: data set while clock high, clock low for 6 cycles, high for 2 more.
  // With popAtFall the CPU pop lands on the same clk edge as the resulting push.
  task automatic ps2Bit(input logic b, input bit popAtFall);
    ps2Data = b;
    repeat (3) @(negedge clk);
    ps2Clk = 1'b0;
    if (popAtFall) begin
      repeat (2) @(negedge clk);
      kbIf.kb_pop = 1'b1;
      @(negedge clk);
      kbIf.kb_pop = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    ps2Clk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full 11-bit frame: start, 8 data LSB-first, odd parity (optionally corrupted), stop
  task automatic applyStimulus(input logic [7:0] code, input bit badParity, input bit popAtPush);
    ps2Bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ps2Bit(code[i], 1'b0);
    end
    ps2Bit((~^code) ^ badParity, 1'b0);
    ps2Bit(1'b1, popAtPush);
    ps2Data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulsePop();
    kbIf.kb_pop = 1'b1;
    @(negedge clk);
    kbIf.kb_pop = 1'b0;
  endtask

  task automatic pulseClear();
    kbIf.kb_clear = 1'b1;
    @(negedge clk);
    kbIf.kb_clear = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    ps2Clk        = 1'b1;
    ps2Data       = 1'b1;
    kbIf.kb_pop   = 1'b0;
    kbIf.kb_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_valid",  32'(kbIf.kb_valid),      32'd0);
    checkOutput("rst_count",  32'(kbIf.kb_count),      32'd0);
    checkOutput("rst_port",   32'(kbIf.input_port_kb), 32'h00);
    checkOutput("rst_ovf",    32'(kbIf.kb_overflow),   32'd0);
    checkOutput("rst_perr",   32'(kbIf.kb_parity_err), 32'd0);

    $display("[TB] single make code");
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkOutput("mk_valid", 32'(kbIf.kb_valid),      32'd1);
    checkOutput("mk_port",  32'(kbIf.input_port_kb), 32'h1C);
    checkOutput("mk_count", 32'(kbIf.kb_count),      32'd1);
    pulsePop();
    checkOutput("pop_valid", 32'(kbIf.kb_valid),      32'd0);
    checkOutput("pop_port",  32'(kbIf.input_port_kb), 32'h00);
    pulsePop();
    checkOutput("pop_empty_count", 32'(kbIf.kb_count), 32'd0);

    $display("[TB] break sequence");
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkOutput("brk_count", 32'(kbIf.kb_count), 32'd0);
    applyStimulus(8'h32, 1'b0, 1'b0);
    checkOutput("brk_next_count", 32'(kbIf.kb_count),      32'd1);
    checkOutput("brk_next_port",  32'(kbIf.input_port_kb), 32'h32);
    pulsePop();

    $display("[TB] extended prefix is queued");
    applyStimulus(KB_EXT_CODE, 1'b0, 1'b0);
    checkOutput("ext_port", 32'(kbIf.input_port_kb), 32'hE0);
    pulsePop();

    $display("[TB] parity error");
    applyStimulus(8'h1C, 1'b1, 1'b0);
    checkOutput("par_flag",  32'(kbIf.kb_parity_err), 32'd1);
    checkOutput("par_count", 32'(kbIf.kb_count),      32'd0);
    pulseClear();
    checkOutput("par_clear", 32'(kbIf.kb_parity_err), 32'd0);

    $display("[TB] overflow");
    applyStimulus(8'h15, 1'b0, 1'b0);
    applyStimulus(8'h1D, 1'b0, 1'b0);
    applyStimulus(8'h24, 1'b0, 1'b0);
    applyStimulus(8'h2D, 1'b0, 1'b0);
    checkOutput("full_ovf_before", 32'(kbIf.kb_overflow), 32'd0);
    applyStimulus(8'h2C, 1'b0, 1'b0);
    checkOutput("ovf_flag",  32'(kbIf.kb_overflow),   32'd1);
    checkOutput("ovf_count", 32'(kbIf.kb_count),      32'd4);
    checkOutput("ovf_head",  32'(kbIf.input_port_kb), 32'h15);
    pulseClear();
    checkOutput("ovf_clear", 32'(kbIf.kb_overflow), 32'd0);

    $display("[TB] push and pop together while full");
    applyStimulus(8'h4D, 1'b0, 1'b1);
    checkOutput("pp_count", 32'(kbIf.kb_count),      32'd4);
    checkOutput("pp_ovf",   32'(kbIf.kb_overflow),   32'd0);
    checkOutput("pp_head",  32'(kbIf.input_port_kb), 32'h1D);
    pulsePop();
    checkOutput("drain_24", 32'(kbIf.input_port_kb), 32'h24);
    pulsePop();
    checkOutput("drain_2D", 32'(kbIf.input_port_kb), 32'h2D);
    pulsePop();
    checkOutput("drain_4D", 32'(kbIf.input_port_kb), 32'h4D);
    pulsePop();
    checkOutput("drain_empty", 32'(kbIf.kb_count), 32'd0);

    $display("[TB] watchdog aborts a stalled frame");
    ps2Bit(1'b0, 1'b0);
    ps2Bit(1'b1, 1'b0);
    ps2Bit(1'b0, 1'b0);
    ps2Bit(1'b1, 1'b0);
    ps2Bit(1'b1, 1'b0);
    ps2Data = 1'b1;
    repeat (TIMEOUT + 100) @(negedge clk);
    checkOutput("wd_count", 32'(kbIf.kb_count), 32'd0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkOutput("wd_next_count", 32'(kbIf.kb_count),      32'd1);
    checkOutput("wd_next_port",  32'(kbIf.input_port_kb), 32'h1C);
    checkOutput("wd_next_perr",  32'(kbIf.kb_parity_err), 32'd0);
    pulsePop();

    $display("[TB] reset mid-frame");
    applyStimulus(8'h21, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(kbIf.kb_count), 32'd2);
    ps2Bit(1'b0, 1'b0);
    ps2Bit(1'b1, 1'b0);
    ps2Bit(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mrst_valid", 32'(kbIf.kb_valid),      32'd0);
    checkOutput("mrst_count", 32'(kbIf.kb_count),      32'd0);
    checkOutput("mrst_port",  32'(kbIf.input_port_kb), 32'h00);
    checkOutput("mrst_ovf",   32'(kbIf.kb_overflow),   32'd0);
    checkOutput("mrst_perr",  32'(kbIf.kb_parity_err), 32'd0);
    rst     = 1'b0;
    ps2Data = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkOutput("post_rst_count", 32'(kbIf.kb_count),      32'd1);
    checkOutput("post_rst_port",  32'(kbIf.input_port_kb), 32'h1C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
